// File: rtl/seq_mult_pkg.sv
// -----------------------------------------------------------------------------
// seq_mult_pkg
// Shared types and constants for the sequential 8x8 multiplier controller.
//   state_e    : controller FSM states (IDLE, MUL, DONE)
//   OP_W       : operand width (8)
//   NIB_W      : nibble width fed to the 4x4 multiplier (4)
//   PROD_W     : product / accumulator width (16)
//   NUM_STEPS  : partial products per operation (4)
//   STEP_W     : width of the step counter (2)
//   step_shift : left shift applied to the partial product of a given step
// -----------------------------------------------------------------------------
package seq_mult_pkg;

    localparam int OP_W      = 8;
    localparam int NIB_W     = 4;
    localparam int PROD_W    = 16;
    localparam int NUM_STEPS = 4;
    localparam int STEP_W    = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Step order: (alo,blo)<<0, (alo,bhi)<<4, (ahi,blo)<<4, (ahi,bhi)<<8.
    function automatic logic [3:0] step_shift(input logic [STEP_W-1:0] step);
        logic [3:0] sh;
        case (step)
            2'd0:    sh = 4'd0;
            2'd1:    sh = 4'd4;
            2'd2:    sh = 4'd4;
            default: sh = 4'd8;
        endcase
        return sh;
    endfunction

endpackage

// File: rtl/seq_mult_8x8_ctrl_if.sv
// -----------------------------------------------------------------------------
// seq_mult_8x8_ctrl_if
// Operand/result handshake bundle of the sequential multiplier.
//   start_valid  : producer offers an operand pair (a, b)
//   start_ready  : block accepts operands (IDLE only)
//   a, b         : unsigned operands, sampled on accept
//   result_valid : product available (DONE only)
//   result_ready : consumer takes the product
//   result       : unsigned product a*b
//   busy         : operation in flight or result pending
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; once valid is raised its payload is held until that edge.
// modport master : producer/consumer side (testbench or upstream logic)
// modport slave  : multiplier side
// -----------------------------------------------------------------------------
interface seq_mult_8x8_ctrl_if;
    import seq_mult_pkg::*;

    logic              start_valid;
    logic              start_ready;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              result_valid;
    logic              result_ready;
    logic [PROD_W-1:0] result;
    logic              busy;

    modport master (
        output start_valid, a, b, result_ready,
        input  start_ready, result_valid, result, busy
    );

    modport slave (
        input  start_valid, a, b, result_ready,
        output start_ready, result_valid, result, busy
    );

endinterface

// File: rtl/four_bit_multiplier.sv
// -----------------------------------------------------------------------------
// four_bit_multiplier
// Combinational 4x4 unsigned array multiplier built from AND rows and adds.
//   A [3:0] : multiplicand nibble
//   B [3:0] : multiplier nibble
//   P [7:0] : unsigned product A*B
// -----------------------------------------------------------------------------
module four_bit_multiplier (
    input  logic [3:0] A,
    input  logic [3:0] B,
    output logic [7:0] P
);

    logic [7:0] sum;

    // Each set bit of B contributes a row equal to A shifted by that bit index.
    always_comb begin
        sum = 8'd0;
        for (int i = 0; i < 4; i++) begin
            if (B[i]) begin
                sum = sum + ({4'd0, A} << i);
            end
        end
    end

    assign P = sum;

endmodule

// File: rtl/seq_mult_8x8_ctrl.sv
// -----------------------------------------------------------------------------
// seq_mult_8x8_ctrl
// Sequential 8x8 unsigned multiplier: one 4x4 partial product per cycle,
// accumulated into a 16-bit register over four MUL cycles.
//   clk     : clock, rising edge
//   rst     : asynchronous active-high reset
//   mult_if : seq_mult_8x8_ctrl_if.slave (operand/result handshake, busy)
//   state_o : current FSM state, for debug/observation
// Optional build macro:
//   SEQ_MULT_ZERO_SKIP_EN : an accept with a zero operand goes straight to
//                           DONE with a zero result (1-edge latency).
// -----------------------------------------------------------------------------
module seq_mult_8x8_ctrl
    import seq_mult_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    seq_mult_8x8_ctrl_if.slave   mult_if,
    output state_e               state_o
);

    state_e              state_q, state_d;
    logic [OP_W-1:0]     a_q, a_d;
    logic [OP_W-1:0]     b_q, b_d;
    logic [PROD_W-1:0]   acc_q, acc_d;
    logic [STEP_W-1:0]   step_q, step_d;

    logic [NIB_W-1:0]    nib_a;
    logic [NIB_W-1:0]    nib_b;
    logic [2*NIB_W-1:0]  pp;
    logic [PROD_W-1:0]   pp_shifted;

    // step bit 1 selects the high nibble of a, step bit 0 the high nibble of b.
    assign nib_a = step_q[1] ? a_q[OP_W-1:NIB_W] : a_q[NIB_W-1:0];
    assign nib_b = step_q[0] ? b_q[OP_W-1:NIB_W] : b_q[NIB_W-1:0];

    four_bit_multiplier u_mul (
        .A (nib_a),
        .B (nib_b),
        .P (pp)
    );

    assign pp_shifted = PROD_W'(pp) << step_shift(step_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        step_d  = step_q;
        case (state_q)
            IDLE: begin
                if (mult_if.start_valid) begin
                    a_d    = mult_if.a;
                    b_d    = mult_if.b;
                    acc_d  = '0;
                    step_d = '0;
`ifdef SEQ_MULT_ZERO_SKIP_EN
                    // Zero product is already in the cleared accumulator.
                    if ((mult_if.a == '0) || (mult_if.b == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = MUL;
                    end
`else
                    state_d = MUL;
`endif
                end
            end
            MUL: begin
                // Max sum is 255*255, so the 16-bit add cannot overflow.
                acc_d  = acc_q + pp_shifted;
                step_d = step_q + STEP_W'(1);
                if (step_q == STEP_W'(NUM_STEPS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (mult_if.result_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign mult_if.start_ready  = (state_q == IDLE);
    assign mult_if.result_valid = (state_q == DONE);
    assign mult_if.busy         = (state_q != IDLE);
    assign mult_if.result       = acc_q;
    assign state_o              = state_q;

endmodule

// File: tb/tb_seq_mult_8x8_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_8x8_ctrl
// Self-checking bench for seq_mult_8x8_ctrl. Expected products come from plain
// integer multiplication; expected latency from the accept-to-valid rule.
// -----------------------------------------------------------------------------
module tb_seq_mult_8x8_ctrl;
    import seq_mult_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_mult_8x8_ctrl_if mif ();
    state_e dbg_state;

    seq_mult_8x8_ctrl dut (
        .clk     (clk),
        .rst     (rst),
        .mult_if (mif),
        .state_o (dbg_state)
    );

    // ---------------- scoreboard ----------------
    int errors = 0;
    int checks = 0;
    logic [15:0] exp_q[$];

    // Reference model: product and edges from accept to result_valid
    // (accept edge counted as edge 1).
    function automatic logic [15:0] model_product(input logic [7:0] a, input logic [7:0] b);
        int unsigned p;
        p = int'(a) * int'(b);
        return p[15:0];
    endfunction

    function automatic int model_latency(input logic [7:0] a, input logic [7:0] b);
`ifdef SEQ_MULT_ZERO_SKIP_EN
        if (a == 8'd0 || b == 8'd0) return 1;
`endif
        return 5;
    endfunction

    // ---------------- driver tasks ----------------
    // One full operation; exp is pushed to the scoreboard queue. stall holds
    // result_ready low for that many cycles after result_valid. noise toggles
    // start_valid while busy, which must have no effect.
    task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                          input logic [15:0] exp, input int stall, input bit noise);
        int n;
        logic [15:0] want;
        logic [15:0] held;
        exp_q.push_back(exp);
        mif.a = a;
        mif.b = b;
        mif.start_valid = 1'b1;
        mif.result_ready = (stall == 0);
        checks++;
        if (mif.start_ready !== 1'b1)
            $display("FAIL %s accept_ready: got %b want 1", name, mif.start_ready);
        if (mif.start_ready !== 1'b1) errors++;
        @(posedge clk); #1;
        n = 1;
        mif.start_valid = 1'b0;
        mif.a = 8'($urandom);
        mif.b = 8'($urandom);
        checks++;
        if (mif.busy !== 1'b1 || mif.start_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_accept: busy=%b start_ready=%b want 1/0",
                     name, mif.busy, mif.start_ready);
        end
        while (mif.result_valid !== 1'b1 && n < 20) begin
            if (noise) begin
                mif.start_valid = 1'($urandom_range(0, 1));
                mif.a = 8'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        mif.start_valid = 1'b0;
        checks++;
        if (n !== model_latency(a, b)) begin
            errors++;
            $display("FAIL %s latency: got %0d edges want %0d", name, n, model_latency(a, b));
        end
        want = exp_q.pop_front();
        checks++;
        if (mif.result !== want) begin
            errors++;
            $display("FAIL %s result: got %h want %h", name, mif.result, want);
        end
        checks++;
        if (mif.start_ready !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_with_valid: start_ready=%b want 0", name, mif.start_ready);
        end
        held = mif.result;
        for (int i = 0; i < stall; i++) begin
            mif.start_valid = 1'($urandom_range(0, 1));
            mif.a = 8'($urandom);
            mif.b = 8'($urandom);
            @(posedge clk); #1;
            checks++;
            if (mif.result_valid !== 1'b1 || mif.result !== held || mif.start_ready !== 1'b0) begin
                errors++;
                $display("FAIL %s backpressure_hold: valid=%b result=%h start_ready=%b want 1/%h/0",
                         name, mif.result_valid, mif.result, mif.start_ready, held);
            end
        end
        mif.start_valid = 1'b0;
        mif.result_ready = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (mif.result_valid !== 1'b0 || mif.start_ready !== 1'b1 || mif.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s return_idle: valid=%b start_ready=%b busy=%b want 0/1/0",
                     name, mif.result_valid, mif.start_ready, mif.busy);
        end
        checks++;
        if (mif.result !== held) begin
            errors++;
            $display("FAIL %s result_kept_idle: got %h want %h", name, mif.result, held);
        end
        mif.result_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (mif.start_ready !== 1'b1 || mif.result_valid !== 1'b0 ||
            mif.result !== 16'h0000 || mif.busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: start_ready=%b valid=%b result=%h busy=%b want 1/0/0000/0",
                     name, mif.start_ready, mif.result_valid, mif.result, mif.busy);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset_during");
        rst = 1'b0;
        @(posedge clk); #1;
        check_reset_outputs("reset_after");
    endtask

    task automatic test_known_vectors();
        run_op("v_12x34", 8'h12, 8'h34, 16'h03A8, 0, 1'b0);
        run_op("v_FFxFF", 8'hFF, 8'hFF, 16'hFE01, 0, 1'b0);
        run_op("v_A5x3C", 8'hA5, 8'h3C, 16'h26AC, 0, 1'b0);
        run_op("v_00x7B", 8'h00, 8'h7B, 16'h0000, 0, 1'b0);
    endtask

    task automatic test_backpressure();
        run_op("bp_stall10", 8'h5A, 8'hC3, model_product(8'h5A, 8'hC3), 10, 1'b0);
    endtask

    task automatic test_reset_mid_op();
        int seen;
        mif.a = 8'h12;
        mif.b = 8'h34;
        mif.start_valid = 1'b1;
        @(posedge clk); #1;
        mif.start_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        checks++;
        if (dbg_state !== MUL || mif.busy !== 1'b1) begin
            errors++;
            $display("FAIL midop_in_mul: state=%0d busy=%b want MUL/1", dbg_state, mif.busy);
        end
        #2 rst = 1'b1;
        #1;
        check_reset_outputs("midop_async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        seen = 0;
        repeat (6) begin
            @(posedge clk); #1;
            if (mif.result_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL midop_no_partial: valid seen %0d cycles want 0", seen);
        end
        run_op("midop_next_03x05", 8'h03, 8'h05, 16'h000F, 0, 1'b0);
    endtask

    task automatic test_back_to_back();
        int cyc;
        int last_acc;
        bit accepting;
        logic [15:0] want;
        cyc = 0;
        last_acc = -1;
        mif.result_ready = 1'b1;
        mif.start_valid = 1'b1;
        mif.a = 8'($urandom_range(1, 255));
        mif.b = 8'($urandom_range(1, 255));
        for (int k = 0; k < 40; k++) begin
            accepting = (mif.start_ready === 1'b1) && mif.start_valid;
            if (accepting) exp_q.push_back(model_product(mif.a, mif.b));
            @(posedge clk); #1;
            cyc++;
            if (accepting) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (cyc - last_acc < 6) begin
                        errors++;
                        $display("FAIL b2b_spacing: got %0d cycles want >= 6", cyc - last_acc);
                    end
                end
                last_acc = cyc;
                mif.a = 8'($urandom_range(1, 255));
                mif.b = 8'($urandom_range(1, 255));
            end
            if (mif.result_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL b2b_unexpected_result: got %h want none", mif.result);
                end else begin
                    want = exp_q.pop_front();
                    if (mif.result !== want) begin
                        errors++;
                        $display("FAIL b2b_result: got %h want %h", mif.result, want);
                    end
                end
            end
        end
        mif.start_valid = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (mif.result_valid === 1'b1 && exp_q.size() != 0) begin
                want = exp_q.pop_front();
                checks++;
                if (mif.result !== want) begin
                    errors++;
                    $display("FAIL b2b_drain_result: got %h want %h", mif.result, want);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0 || mif.busy !== 1'b0) begin
            errors++;
            $display("FAIL b2b_drain: pending=%0d busy=%b want 0/0", exp_q.size(), mif.busy);
            exp_q.delete();
        end
        mif.result_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [7:0] ra;
        logic [7:0] rb;
        for (int k = 0; k < 12; k++) begin
            ra = (k % 5 == 4) ? 8'h00 : 8'($urandom);
            rb = 8'($urandom);
            run_op("rand_op", ra, rb, model_product(ra, rb), $urandom_range(0, 3), 1'b1);
        end
    endtask

    // ---------------- main sequence + report ----------------
    initial begin
        rst = 1'b1;
        mif.start_valid = 1'b0;
        mif.result_ready = 1'b0;
        mif.a = 8'h00;
        mif.b = 8'h00;
        test_reset();
        test_known_vectors();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "watchdog");
    end

endmodule
